// File: rtl/lc3b_mem_arbiter_pkg.sv
// lc3b_mem_arbiter_pkg
// Shared types for the LC-3b two-port memory arbiter: word and mask types,
// FSM state and port enums, the latched request bundle and the grant-selection
// helper. No ports (package).
package lc3b_mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } lc3b_arb_port;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask wmask;
  } lc3b_arb_req;

  localparam lc3b_arb_req REQ_NONE = '{
    read: 1'b0, write: 1'b0, address: 16'h0000, wdata: 16'h0000, wmask: 2'b00
  };

  // A lone pending port wins; on a tie the port that did not win last time wins.
  function automatic lc3b_arb_port pick_port(input logic pend_a, input logic pend_b,
                                             input lc3b_arb_port last);
    lc3b_arb_port p;
    p = PORT_A;
    if (pend_a && pend_b) begin
      if (last == PORT_A) p = PORT_B;
      else                p = PORT_A;
    end else if (pend_b) begin
      p = PORT_B;
    end else begin
      p = PORT_A;
    end
    return p;
  endfunction

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// lc3b_mem_arbiter_if
// One memory port: request strobes, address, write data and byte mask flow
// from master to slave; the one-cycle response and read data flow back.
//   master: the side issuing requests (datapath port, or the arbiter downstream)
//   slave : the side serving requests (arbiter upstream, or physical memory)
interface lc3b_mem_arbiter_if;
  import lc3b_mem_arbiter_pkg::*;

  logic          read;
  logic          write;
  lc3b_word      address;
  lc3b_word      wdata;
  lc3b_mem_wmask wmask;
  logic          resp;
  lc3b_word      rdata;

  modport master (output read, write, address, wdata, wmask, input  resp, rdata);
  modport slave  (input  read, write, address, wdata, wmask, output resp, rdata);

endinterface

// File: rtl/arb_req_reg.sv
// arb_req_reg
// Holds the granted request so the downstream port sees stable values for the
// whole transaction, independent of what the requester does meanwhile.
//   clk, reset    : clock, asynchronous active-high reset
//   load          : capture req_in (grant cycle)
//   clear_strobes : drop read/write after the downstream response
//   req_in        : request bundle of the port being granted
//   req_q         : registered request bundle, drives the downstream port
module arb_req_reg
  import lc3b_mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear_strobes,
  input  lc3b_arb_req req_in,
  output lc3b_arb_req req_q
);

  lc3b_arb_req req_r;

  // Request register: load on grant, strobes cleared on completion, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_r <= REQ_NONE;
    end else if (load) begin
      req_r <= req_in;
    end else if (clear_strobes) begin
      req_r.read  <= 1'b0;
      req_r.write <= 1'b0;
    end else begin
      req_r <= req_r;
    end
  end

  assign req_q = req_r;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter
// Serialises the LC-3b instruction port (A) and data port (B) onto one
// downstream memory port, one transaction at a time, alternating on ties.
//   clk, reset : clock, asynchronous active-high reset
//   port_a     : instruction-fetch requester (slave side)
//   port_b     : data requester (slave side)
//   pmem       : downstream memory (master side)
module lc3b_mem_arbiter
  import lc3b_mem_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  lc3b_mem_arbiter_if.slave   port_a,
  lc3b_mem_arbiter_if.slave   port_b,
  lc3b_mem_arbiter_if.master  pmem
);

  lc3b_arb_state state_r;
  lc3b_arb_state next_state_s;
  lc3b_arb_port  last_grant_r;
  lc3b_arb_port  grant_s;
  logic          load_s;
  logic          clear_s;
  logic          pend_a_s;
  logic          pend_b_s;
  lc3b_arb_req   req_a_s;
  lc3b_arb_req   req_b_s;
  lc3b_arb_req   req_in_s;
  lc3b_arb_req   req_s;

  assign pend_a_s = port_a.read | port_a.write;
  assign pend_b_s = port_b.read | port_b.write;

  assign req_a_s = '{read: port_a.read, write: port_a.write, address: port_a.address,
                     wdata: port_a.wdata, wmask: port_a.wmask};
  assign req_b_s = '{read: port_b.read, write: port_b.write, address: port_b.address,
                     wdata: port_b.wdata, wmask: port_b.wmask};

  // Next-state and grant decode; only IDLE looks at the requesters.
  always_comb begin
    next_state_s = state_r;
    grant_s      = last_grant_r;
    load_s       = 1'b0;
    clear_s      = 1'b0;
    req_in_s     = REQ_NONE;
    case (state_r)
      IDLE: begin
        if (pend_a_s || pend_b_s) begin
          grant_s = pick_port(pend_a_s, pend_b_s, last_grant_r);
          load_s  = 1'b1;
          if (grant_s == PORT_B) begin
            next_state_s = SERVE_B;
            req_in_s     = req_b_s;
          end else begin
            next_state_s = SERVE_A;
            req_in_s     = req_a_s;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      SERVE_A, SERVE_B: begin
        // Downstream cannot abort, so only its response ends a transaction.
        if (pmem.resp) begin
          next_state_s = IDLE;
          clear_s      = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state and most-recent-grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= PORT_A;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        last_grant_r <= grant_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  arb_req_reg u_req_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (load_s),
    .clear_strobes (clear_s),
    .req_in        (req_in_s),
    .req_q         (req_s)
  );

  // Downstream port is driven purely from the request register.
  assign pmem.read    = req_s.read;
  assign pmem.write   = req_s.write;
  assign pmem.address = req_s.address;
  assign pmem.wdata   = req_s.wdata;
  assign pmem.wmask   = req_s.wmask;

  // Response routed only to the port being served; read data is shared.
  assign port_a.resp  = pmem.resp & (state_r == SERVE_A);
  assign port_b.resp  = pmem.resp & (state_r == SERVE_B);
  assign port_a.rdata = pmem.rdata;
  assign port_b.rdata = pmem.rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb_lc3b_mem_arbiter
// Directed plus randomized bench. The bench keeps each requester's held
// request in its own arrays and predicts the grant from the arbitration rules
// (lone requester wins, ties go opposite the previous grant, A after reset).
module tb_lc3b_mem_arbiter;
  import lc3b_mem_arbiter_pkg::*;

  logic clk;
  logic reset;

  lc3b_mem_arbiter_if a_if ();
  lc3b_mem_arbiter_if b_if ();
  lc3b_mem_arbiter_if p_if ();

  lc3b_mem_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .port_a (a_if),
    .port_b (b_if),
    .pmem   (p_if)
  );

  int checks = 0;
  int errors = 0;

  logic        rq_read  [2];
  logic        rq_write [2];
  logic [15:0] rq_addr  [2];
  logic [15:0] rq_wdata [2];
  logic [1:0]  rq_wmask [2];
  int          last_port;

  logic        stg_valid;
  int          stg_port;
  logic        stg_read, stg_write;
  logic [15:0] stg_addr, stg_wdata;
  logic [1:0]  stg_wmask;

  int got;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    a_if.read = rq_read[0]; a_if.write = rq_write[0]; a_if.address = rq_addr[0];
    a_if.wdata = rq_wdata[0]; a_if.wmask = rq_wmask[0];
    b_if.read = rq_read[1]; b_if.write = rq_write[1]; b_if.address = rq_addr[1];
    b_if.wdata = rq_wdata[1]; b_if.wmask = rq_wmask[1];
  endtask

  task automatic set_req(input int p, input logic rd, input logic wr,
                         input logic [15:0] ad, input logic [15:0] wd, input logic [1:0] wm);
    rq_read[p] = rd; rq_write[p] = wr; rq_addr[p] = ad; rq_wdata[p] = wd; rq_wmask[p] = wm;
  endtask

  task automatic clear_port(input int p);
    set_req(p, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
  endtask

  task automatic rand_req(input int p);
    int kind;
    kind = int'($urandom_range(0, 2));
    set_req(p, kind != 1, kind != 0, 16'($urandom), 16'($urandom), 2'($urandom));
  endtask

  function automatic logic pending(input int p);
    return rq_read[p] | rq_write[p];
  endfunction

  function automatic int model_grant();
    if (pending(0) && pending(1)) return 1 - last_port;
    if (pending(1)) return 1;
    return 0;
  endfunction

  function automatic logic resp_of(input int p);
    return (p == 0) ? a_if.resp : b_if.resp;
  endfunction

  function automatic logic [15:0] rdata_of(input int p);
    return (p == 0) ? a_if.rdata : b_if.rdata;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    clear_port(0); clear_port(1);
    p_if.resp = 1'b0; p_if.rdata = 16'h0000;
    stg_valid = 1'b0;
    apply();
    repeat (2) @(negedge clk);
    #1;
    check("rst_pmem_read", 16'(p_if.read), 16'h0000);
    check("rst_pmem_write", 16'(p_if.write), 16'h0000);
    check("rst_pmem_address", p_if.address, 16'h0000);
    check("rst_pmem_wdata", p_if.wdata, 16'h0000);
    check("rst_pmem_wmask", 16'(p_if.wmask), 16'h0000);
    check("rst_resp_a", 16'(a_if.resp), 16'h0000);
    check("rst_resp_b", 16'(b_if.resp), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    last_port = 0;
  endtask

  // Called in an IDLE cycle with requests already set; runs one transaction
  // with the response lat cycles after the grant and returns at the following
  // IDLE cycle with the served requester's request withdrawn.
  task automatic serve(input int lat, input logic [15:0] rd, input int drop_at,
                       input int move_at, input int inject_at, output int got_port);
    int p;
    logic er, ew;
    logic [15:0] ea, ewd;
    logic [1:0] em;
    p = model_grant();
    er = rq_read[p]; ew = rq_write[p]; ea = rq_addr[p]; ewd = rq_wdata[p]; em = rq_wmask[p];
    last_port = p;
    got_port = -1;
    apply();
    #1;
    check("gap_pmem_read", 16'(p_if.read), 16'h0000);
    check("gap_pmem_write", 16'(p_if.write), 16'h0000);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == drop_at) begin rq_read[p] = 1'b0; rq_write[p] = 1'b0; end
      if (c == move_at) begin rq_addr[p] = rq_addr[p] ^ 16'h5a5a; rq_wdata[p] = ~rq_wdata[p]; end
      if (c == inject_at && stg_valid && !pending(stg_port)) begin
        set_req(stg_port, stg_read, stg_write, stg_addr, stg_wdata, stg_wmask);
        stg_valid = 1'b0;
      end
      if (c == lat) begin p_if.resp = 1'b1; p_if.rdata = rd; end
      apply();
      #1;
      check("pmem_read", 16'(p_if.read), 16'(er));
      check("pmem_write", 16'(p_if.write), 16'(ew));
      check("pmem_address", p_if.address, ea);
      check("pmem_wdata", p_if.wdata, ewd);
      check("pmem_wmask", 16'(p_if.wmask), 16'(em));
      if (c == lat) begin
        check("resp_granted", 16'(resp_of(p)), 16'h0001);
        check("resp_other", 16'(resp_of(1 - p)), 16'h0000);
        check("rdata_granted", rdata_of(p), rd);
        if (a_if.resp) got_port = 0;
        else if (b_if.resp) got_port = 1;
        else got_port = -1;
      end else begin
        check("resp_a_wait", 16'(a_if.resp), 16'h0000);
        check("resp_b_wait", 16'(b_if.resp), 16'h0000);
      end
    end
    @(negedge clk);
    p_if.resp = 1'b0;
    p_if.rdata = 16'($urandom);
    clear_port(p);
    stg_valid = 1'b0;
    apply();
    #1;
    check("post_pmem_read", 16'(p_if.read), 16'h0000);
    check("post_pmem_write", 16'(p_if.write), 16'h0000);
    check("post_resp_a", 16'(a_if.resp), 16'h0000);
    check("post_resp_b", 16'(b_if.resp), 16'h0000);
  endtask

  initial begin
    last_port = 0;

    // Single A read of 0x0100, response three cycles after the grant.
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00);
    serve(3, 16'h1234, 0, 0, 0, got);
    check("single_a_port", 16'(got), 16'h0000);

    // Both ports requesting continuously from the first cycle after reset:
    // B first, then strict alternation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (!pending(0)) set_req(0, 1'b1, 1'b0, 16'h0a00 + 16'(i), 16'h0000, 2'b11);
      if (!pending(1)) set_req(1, 1'b0, 1'b1, 16'h0b00 + 16'(i), 16'hc000 + 16'(i), 2'b10);
      serve(int'($urandom_range(1, 3)), 16'($urandom), 0, 0, 0, got);
      check("alternate_port", 16'(got), (i % 2 == 0) ? 16'h0001 : 16'h0000);
    end
    clear_port(0); clear_port(1); apply();
    @(negedge clk);

    // B write arrives while an A read is in flight; B waits, then forwards exactly.
    set_req(0, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b00);
    stg_valid = 1'b1; stg_port = 1;
    stg_read = 1'b0; stg_write = 1'b1; stg_addr = 16'h2000; stg_wdata = 16'hbeef; stg_wmask = 2'b01;
    serve(3, 16'h5555, 0, 0, 1, got);
    check("inflight_a_port", 16'(got), 16'h0000);
    check("b_still_waiting", 16'(b_if.write), 16'h0001);
    serve(2, 16'h0000, 0, 0, 0, got);
    check("b_after_a_port", 16'(got), 16'h0001);

    // A drops its read two cycles into service; transaction still completes.
    set_req(0, 1'b1, 1'b0, 16'h0400, 16'h0000, 2'b00);
    serve(5, 16'h7777, 2, 3, 0, got);
    check("drop_a_port", 16'(got), 16'h0000);

    // Randomized traffic, including mid-service drops, address changes and
    // late arrivals on the idle port.
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pending(p) && $urandom_range(0, 1) == 1) rand_req(p);
      end
      if (!pending(0) && !pending(1)) rand_req(int'($urandom_range(0, 1)));
      stg_valid = ($urandom_range(0, 2) == 0);
      stg_port = int'($urandom_range(0, 1));
      stg_read = 1'b1; stg_write = $urandom_range(0, 1) == 1;
      stg_addr = 16'($urandom); stg_wdata = 16'($urandom); stg_wmask = 2'($urandom);
      serve(int'($urandom_range(1, 4)), 16'($urandom), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), got);
    end
    clear_port(0); clear_port(1); apply();
    @(negedge clk);

    // Reset in the middle of a B read, with the response arriving during reset.
    set_req(1, 1'b1, 1'b0, 16'h0500, 16'h0000, 2'b00);
    apply();
    @(negedge clk);
    #1;
    check("serve_b_read", 16'(p_if.read), 16'h0001);
    check("serve_b_address", p_if.address, 16'h0500);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_read", 16'(p_if.read), 16'h0000);
    check("async_rst_write", 16'(p_if.write), 16'h0000);
    p_if.resp = 1'b1; p_if.rdata = 16'h9999;
    #1;
    check("rst_resp_a_supp", 16'(a_if.resp), 16'h0000);
    check("rst_resp_b_supp", 16'(b_if.resp), 16'h0000);
    @(negedge clk);
    #1;
    check("rst_hold_resp_b", 16'(b_if.resp), 16'h0000);
    check("rst_hold_read", 16'(p_if.read), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    p_if.resp = 1'b0;
    last_port = 0;
    // After release the arbiter is idle and a tie goes to B (last grant A).
    set_req(0, 1'b1, 1'b0, 16'h0600, 16'h0000, 2'b00);
    set_req(1, 1'b0, 1'b1, 16'h0700, 16'h1111, 2'b11);
    serve(1, 16'h2222, 0, 0, 0, got);
    check("post_rst_tie_port", 16'(got), 16'h0001);
    serve(2, 16'h3333, 0, 0, 0, got);
    check("post_rst_second_port", 16'(got), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_arbiter.md
# lc3b_mem_arbiter

Two-port-to-one memory arbiter between the LC-3b pipelined datapath and the unified downstream memory (physical memory or L2). It accepts the datapath's instruction-fetch port (A) and data port (B) requests and serialises them onto a single downstream port. It returns each downstream response only to the granted requester. Requests are held by the requester until it sees its response.

## Interface
Parameters:
- none; word width is fixed by `lc3b_word` (16 bits), mask width is 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_read_a`, `mem_write_a`  in  1  port A (instruction) request strobes; held until `mem_resp_a`.
- `mem_address_a`, `mem_wdata_a`  in  16  port A address / write data.
- `mem_wmask_a`  in  2  port A byte mask.
- `mem_resp_a`  out  1  port A completion, one cycle.
- `mem_rdata_a`  out  16  port A read data; valid when `mem_resp_a`=1.
- `mem_read_b`, `mem_write_b`, `mem_address_b`, `mem_wdata_b`, `mem_wmask_b`, `mem_resp_b`, `mem_rdata_b`  are the same as port A, for port B (data).
- `pmem_read`, `pmem_write`  out  1  downstream request strobes.
- `pmem_address`, `pmem_wdata`  out  16  downstream address / write data.
- `pmem_wmask`  out  2  downstream byte mask.
- `pmem_resp`  in  1  downstream completion, one cycle.
- `pmem_rdata`  in  16  downstream read data.

## Operation
- FSM states: IDLE, SERVE_A, SERVE_B. A `last_grant` flop records the most recently granted port; it resets to A.
- IDLE, grant selection:
  - port X is "pending" when `mem_read_x | mem_write_x`.
  - If only one port is pending, that port is granted.
  - If both are pending, the port opposite `last_grant` is granted. The first tie after reset therefore goes to B.
  - If neither is pending, the FSM stays in IDLE.
- On a grant, the FSM latches the granted port's read, write, address, wdata and wmask into request registers. It then moves to SERVE_x and sets `last_grant`=x.
- SERVE_x:
  - `pmem_read`/`pmem_write`/`pmem_address`/`pmem_wdata`/`pmem_wmask` are driven from the request registers, so they are stable for the whole transaction.
  - On `pmem_resp`=1 the block asserts `mem_resp_x` in the same cycle and returns to IDLE at the next edge.
- `mem_rdata_a` and `mem_rdata_b` are both wired to `pmem_rdata` at all times.
- `mem_resp_a` is `pmem_resp & (state==SERVE_A)`; `mem_resp_b` likewise for SERVE_B.
- Read and write both asserted on one port: the latched request forwards both strobes unchanged. Legality is the requester's responsibility.
- Requester drops its request mid-service: the transaction still completes downstream, because downstream cannot abort. `mem_resp_x` is still pulsed, and the FSM returns to IDLE normally.
- Request changes address mid-service: ignored. The latched values are used.

## Timing
- Reset values:
  - state IDLE, `last_grant`=A, request registers 0.
  - `pmem_read`=`pmem_write`=0, `pmem_address`=`pmem_wdata`=0, `pmem_wmask`=0.
  - `mem_resp_a`=`mem_resp_b`=0.
- Reset is asynchronous. Asserted mid-transaction, it forces all `pmem_*` strobes low immediately and suppresses any in-flight response.
- Latency:
  - a request first seen in IDLE at cycle T drives `pmem_*` from cycle T+1.
  - if `pmem_resp` arrives at cycle N ≥ T+1, `mem_resp_x` is asserted at N.
  - minimum request-to-response is 2 cycles.
- Back-to-back: after a response at N, IDLE at N+1 evaluates requests. The next grant drives `pmem_*` at N+2, so there is one dead downstream cycle between transactions.
- Never more than one outstanding downstream transaction.

## Structure
- Add `lc3b_arb_state` (enum: IDLE, SERVE_A, SERVE_B) and `lc3b_arb_port` (enum: PORT_A, PORT_B) to `lc3b_types`.
- No sub-module is needed for the FSM. The request-register bundle (read, write, 16-bit address, 16-bit wdata, 2-bit wmask) is one natural sub-module, `arb_req_reg`, instantiated once.

## Test plan
- Single A read to 0x0100, `pmem_resp` 3 cycles later with rdata 0x1234:
  - required: `pmem_read`=1 with address 0x0100 from T+1.
  - `mem_resp_a`=1 and `mem_rdata_a`=0x1234 in the same cycle as `pmem_resp`.
  - `mem_resp_b` stays 0.
- A and B both request at the first cycle after reset:
  - required: B is served first.
  - then A, with one IDLE cycle between the two.
  - `last_grant` alternates B→A.
- B write (0x2000, wdata 0xBEEF, wmask 2'b01) while an A read is in flight:
  - required: B waits until A's response.
  - B then forwards exactly 0x2000 / 0xBEEF / 01.
- Continuous A and B requests for 8 transactions:
  - required: grants strictly alternate A/B.
  - no port waits more than one transaction.
- A drops `mem_read_a` two cycles into service:
  - required: `pmem_read` stays 1 until `pmem_resp`.
  - `mem_resp_a` pulses, and the FSM returns to IDLE.
- `reset` asserted mid-SERVE_B, with `pmem_resp` arriving during reset:
  - required: `pmem_read` and `pmem_write` go 0 asynchronously.
  - no `mem_resp_*` is asserted.
  - after release, state is IDLE and `last_grant`=A.
